// File: rtl/vga_frame_capture.sv
// vga_frame_capture
// Samples an incoming VGA stream (HS/VS active-low, blank=1 on visible
// pixels), measures line/frame timing, and writes a 2x2-decimated image
// into video memory at (y/2)*320 + x/2.
//
// Ports:
//   vga_clock    pixel clock, the only clock
//   reset        synchronous, active-high
//   capture_en   level; arms capture and keeps continuous capture going
//   vga_hs/vs    sync inputs, active-low
//   vga_blank    1 = visible pixel
//   pixel_in     8-bit pixel
//   mem_wr_en    one-cycle write strobe
//   mem_address  17-bit write address
//   mem_data     write data
//   frame_done   one-cycle pulse at the end of each captured frame
//   capturing    high while in CAPTURE
//   locked       timing has matched H_TOTAL/V_TOTAL for two good frames
//   sync_error   sticky timing/geometry error, cleared on CAPTURE entry
//   line_period  last measured clocks per line
//   frame_lines  last measured lines per frame
module vga_frame_capture #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic        capture_en,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank,
    input  logic [7:0]  pixel_in,
    output logic        mem_wr_en,
    output logic [16:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        frame_done,
    output logic        capturing,
    output logic        locked,
    output logic        sync_error,
    output logic [9:0]  line_period,
    output logic [9:0]  frame_lines
);

    localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_L = 11'(V_TOTAL);
    localparam logic [10:0] H_PIX_L = 11'(H_PIXELS);
    localparam logic [10:0] V_PIX_L = 11'(V_PIXELS);
    localparam logic [16:0] ADDR_MAX = 17'd76799;

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;

    state_t      state;
    logic        s1_hs, s1_vs, s1_blank, s2_hs, s2_vs;
    logic [7:0]  s1_pix;
    logic [9:0]  h_cnt, line_cnt, x;
    logic [8:0]  y;
    logic        line_vis;
    logic        h_seen, v_seen;   // first edge after reset only starts measurement
    logic        frame_ok;         // every line of the current frame was good
    logic        prev_good;        // previous frame was good

    logic        hs_fall, vs_fall, h_sat, bad_line, bad_frame;
    logic        in_range, wr_cond, pix_err, enter_capture;
    logic [10:0] h_meas, lines_meas;
    logic [7:0]  yh;
    logic [16:0] addr_raw, addr_clamp;

    assign hs_fall = s2_hs & ~s1_hs;
    assign vs_fall = s2_vs & ~s1_vs;

    assign h_sat    = (h_cnt == 10'h3FF);
    assign h_meas   = {1'b0, h_cnt} + 11'd1;
    assign bad_line = hs_fall && h_seen && (h_sat || h_meas != H_TOT_L);

    // A simultaneous hs_fall belongs to the frame being closed.
    assign lines_meas = {1'b0, line_cnt} + {10'b0, hs_fall};
    assign bad_frame  = vs_fall && v_seen &&
                        (lines_meas >= 11'd1023 || lines_meas != V_TOT_L);

    assign in_range = ({1'b0, x} < H_PIX_L) && ({2'b0, y} < V_PIX_L);
    assign wr_cond  = (state == CAPTURE) && s1_blank && in_range && !x[0] && !y[0];
    assign pix_err  = s1_blank && !in_range;
    assign enter_capture = (state == ARM) && capture_en && vs_fall;

    // (y/2)*256 + (y/2)*64 + x/2
    assign yh         = y[8:1];
    assign addr_raw   = {1'b0, yh, 8'b0} + {3'b0, yh, 6'b0} + {8'b0, x[9:1]};
    assign addr_clamp = (addr_raw > ADDR_MAX) ? ADDR_MAX : addr_raw;

    // Input sampling keeps running through reset so edge detection never
    // sees a fabricated edge when reset is released.
    always_ff @(posedge vga_clock) begin
        s1_hs    <= vga_hs;
        s1_vs    <= vga_vs;
        s1_blank <= vga_blank;
        s1_pix   <= pixel_in;
        s2_hs    <= s1_hs;
        s2_vs    <= s1_vs;
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state       <= IDLE;
            h_cnt       <= '0;
            line_cnt    <= '0;
            x           <= '0;
            y           <= '0;
            line_vis    <= 1'b0;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            frame_ok    <= 1'b0;
            prev_good   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            frame_done  <= 1'b0;
            capturing   <= 1'b0;
            locked      <= 1'b0;
            sync_error  <= 1'b0;
            line_period <= '0;
            frame_lines <= '0;
        end else begin
            // line timing
            if (hs_fall) begin
                h_cnt  <= '0;
                h_seen <= 1'b1;
                if (h_seen)
                    line_period <= h_sat ? 10'h3FF : h_meas[9:0];
                if (line_cnt != 10'h3FF)
                    line_cnt <= line_cnt + 10'd1;
            end else if (!h_sat) begin
                h_cnt <= h_cnt + 10'd1;
            end

            // frame timing; overrides the line_cnt increment above
            if (vs_fall) begin
                line_cnt <= '0;
                v_seen   <= 1'b1;
                if (v_seen)
                    frame_lines <= lines_meas[10] ? 10'h3FF : lines_meas[9:0];
            end

            // pixel position
            if (hs_fall)
                x <= '0;
            else if (s1_blank && x != 10'h3FF)
                x <= x + 10'd1;

            if (vs_fall) begin
                y        <= '0;
                line_vis <= 1'b0;
            end else if (hs_fall) begin
                if (line_vis && y != 9'h1FF)
                    y <= y + 9'd1;
                line_vis <= 1'b0;
            end else if (s1_blank) begin
                line_vis <= 1'b1;
            end

            // lock tracking
            if (vs_fall) begin
                frame_ok <= 1'b1;
                if (v_seen)
                    prev_good <= !(bad_frame || bad_line || !frame_ok);
            end else if (bad_line) begin
                frame_ok <= 1'b0;
            end

            if (bad_line || bad_frame)
                locked <= 1'b0;
            else if (vs_fall && v_seen && frame_ok && prev_good)
                locked <= 1'b1;

            // an error seen in the same cycle as CAPTURE entry is kept
            if (bad_line || bad_frame || pix_err)
                sync_error <= 1'b1;
            else if (enter_capture)
                sync_error <= 1'b0;

            // memory write port
            mem_wr_en <= wr_cond;
            if (wr_cond) begin
                mem_address <= addr_clamp;
                mem_data    <= s1_pix;
            end

            // capture control
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    capturing <= 1'b0;
                    if (capture_en)
                        state <= ARM;
                end
                ARM: begin
                    if (!capture_en) begin
                        state     <= IDLE;
                        capturing <= 1'b0;
                    end else if (vs_fall) begin
                        state     <= CAPTURE;
                        capturing <= 1'b1;
                    end
                end
                CAPTURE: begin
                    // a frame in progress always completes
                    if (vs_fall) begin
                        frame_done <= 1'b1;
                        if (!capture_en) begin
                            state     <= IDLE;
                            capturing <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    capturing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture
// Drives a reduced-size VGA stream (40 clocks x 24 lines, 16x12 visible)
// with random pixels and compares the memory writes, frame_done pulses and
// timing status against expectations derived from the stream geometry.
module tb_vga_frame_capture;

    localparam int HT    = 40;   // clocks per line
    localparam int VT    = 24;   // lines per frame
    localparam int HP    = 16;   // visible pixels per line
    localparam int VP    = 12;   // visible lines per frame
    localparam int HB    = 8;    // first visible clock in a line
    localparam int VL0   = 4;    // first visible line in a frame
    localparam int RST_H = 12;   // clock within a line where mid-frame reset starts

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        capture_en = 1'b0;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic        vga_blank = 1'b0;
    logic [7:0]  pixel_in = 8'd0;
    logic        mem_wr_en, frame_done, capturing, locked, sync_error;
    logic [16:0] mem_address;
    logic [7:0]  mem_data;
    logic [9:0]  line_period, frame_lines;

    typedef struct packed {
        int          cyc;
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t  exp_w[$];
    wr_t  got_w[$];
    int   exp_done[$];
    int   got_done[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   short_end = 0;
    int   drop_cyc = -1;
    logic [9:0] drop_lp = '0;
    logic prev_locked = 1'b0;
    bit   prev_capt = 1'b0;

    vga_frame_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .H_PIXELS(HP), .V_PIXELS(VP)) dut (
        .vga_clock   (clk),
        .reset       (reset),
        .capture_en  (capture_en),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank   (vga_blank),
        .pixel_in    (pixel_in),
        .mem_wr_en   (mem_wr_en),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .frame_done  (frame_done),
        .capturing   (capturing),
        .locked      (locked),
        .sync_error  (sync_error),
        .line_period (line_period),
        .frame_lines (frame_lines)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Recorder: outputs are sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) got_w.push_back('{cyc, mem_address, mem_data});
        if (frame_done === 1'b1) got_done.push_back(cyc);
        if (prev_locked === 1'b1 && locked === 1'b0) begin
            drop_cyc = cyc;
            drop_lp  = line_period;
        end
        prev_locked = locked;
    end

    // One frame of stream. Starts with VS and HS falling together. A frame
    // marked capt has every visible pixel with even x and even y expected in
    // memory two cycles after it is on the pins, at (y/2)*320 + x/2.
    task automatic drive_frame(input bit capt, input int en_line, input bit en_val,
                               input int short_line, input int long_line, input int rst_line);
        bit killed = 1'b0;
        bit vis;
        int vx, vy, len, blen;
        for (int l = 0; l < VT; l++) begin
            len  = (l == short_line) ? HT - 1 : HT;
            blen = (l == long_line) ? HP + 2 : HP;
            for (int h = 0; h < len; h++) begin
                @(posedge clk); #1;
                if (l == 0 && h == 0 && prev_capt) exp_done.push_back(cyc + 2);
                if (l == en_line && h == 0) capture_en = en_val;
                if (l == rst_line) begin
                    reset = (h >= RST_H && h < RST_H + 3);
                    // a pixel one cycle before reset would land after the reset edge
                    if (h == RST_H - 1) killed = 1'b1;
                end
                if (short_line >= 0 && l == short_line + 1 && h == 0) short_end = cyc;
                vis       = (l >= VL0 && l < VL0 + VP && h >= HB && h < HB + blen);
                vga_hs    = (h >= 4);
                vga_vs    = (l >= 2);
                vga_blank = vis;
                pixel_in  = 8'($urandom);
                if (vis && capt && !killed) begin
                    vx = h - HB;
                    vy = l - VL0;
                    if (vx < HP && vx % 2 == 0 && vy % 2 == 0)
                        exp_w.push_back('{cyc + 2, 17'((vy / 2) * 320 + vx / 2), pixel_in});
                end
            end
        end
        prev_capt = capt && !killed;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vga_blank = 1'($urandom);
            pixel_in  = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({mem_wr_en, frame_done, capturing, locked, sync_error, mem_address, mem_data,
                 line_period, frame_lines} !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: wr=%b done=%b cap=%b lock=%b err=%b addr=%0d data=%0h lp=%0d fl=%0d want all 0",
                         i, mem_wr_en, frame_done, capturing, locked, sync_error, mem_address,
                         mem_data, line_period, frame_lines);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        vga_blank = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({capturing, locked, sync_error, frame_done, mem_address, line_period, frame_lines} !== '0) begin
            errors++;
            $display("FAIL reset_release: cap=%b lock=%b err=%b done=%b addr=%0d lp=%0d fl=%0d want all 0",
                     capturing, locked, sync_error, frame_done, mem_address, line_period, frame_lines);
        end
        checks++;
        if (got_w.size() != 0) begin
            errors++;
            $display("FAIL reset_writes: got %0d writes want 0", got_w.size());
        end
        got_w.delete();
        got_done.delete();
    endtask

    task automatic test_no_capture;
        drive_frame(0, -1, 0, -1, -1, -1);
        drive_frame(0, -1, 0, -1, -1, -1);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: got %b want 0", locked);
        end
        drive_frame(0, -1, 0, -1, -1, -1);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_rise: got %b want 1", locked);
        end
        checks++;
        if (line_period !== 10'(HT) || frame_lines !== 10'(VT)) begin
            errors++;
            $display("FAIL measure: got lp=%0d fl=%0d want lp=%0d fl=%0d", line_period, frame_lines, HT, VT);
        end
        checks++;
        if (sync_error !== 1'b0 || capturing !== 1'b0) begin
            errors++;
            $display("FAIL idle_status: got err=%b cap=%b want 0 0", sync_error, capturing);
        end
        checks++;
        if (got_w.size() != 0 || got_done.size() != 0) begin
            errors++;
            $display("FAIL idle_activity: got writes=%0d done=%0d want 0 0", got_w.size(), got_done.size());
        end
        got_w.delete();
        got_done.delete();
    endtask

    task automatic test_full_frame;
        drive_frame(0, 12, 1, -1, -1, -1);   // arm mid-frame
        checks++;
        if (capturing !== 1'b0 || sync_error !== 1'b0) begin
            errors++;
            $display("FAIL armed_status: got cap=%b err=%b want 0 0", capturing, sync_error);
        end
        drive_frame(1, -1, 0, -1, -1, -1);
        checks++;
        if (capturing !== 1'b1 || locked !== 1'b1 || sync_error !== 1'b0) begin
            errors++;
            $display("FAIL capture_status: got cap=%b lock=%b err=%b want 1 1 0", capturing, locked, sync_error);
        end
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL full_frame count: got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL full_frame write %0d: got cyc=%0d addr=%0d data=%0h want cyc=%0d addr=%0d data=%0h",
                         i, got_w[i].cyc, got_w[i].addr, got_w[i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        checks++;
        if (got_done.size() != exp_done.size()) begin
            errors++;
            $display("FAIL full_frame done count: got %0d want %0d", got_done.size(), exp_done.size());
        end
        got_w.delete(); exp_w.delete(); got_done.delete(); exp_done.delete();
    endtask

    task automatic test_long_blank;
        drive_frame(1, -1, 0, -1, 6, -1);
        checks++;
        if (sync_error !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL long_blank status: got err=%b lock=%b want 1 1", sync_error, locked);
        end
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL long_blank count: got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL long_blank write %0d: got cyc=%0d addr=%0d data=%0h want cyc=%0d addr=%0d data=%0h",
                         i, got_w[i].cyc, got_w[i].addr, got_w[i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        checks++;
        if (got_done.size() != exp_done.size()) begin
            errors++;
            $display("FAIL long_blank done count: got %0d want %0d", got_done.size(), exp_done.size());
        end
        for (int i = 0; i < got_done.size() && i < exp_done.size(); i++) begin
            checks++;
            if (got_done[i] !== exp_done[i]) begin
                errors++;
                $display("FAIL long_blank done %0d: got cyc=%0d want cyc=%0d", i, got_done[i], exp_done[i]);
            end
        end
        got_w.delete(); exp_w.delete(); got_done.delete(); exp_done.delete();
    endtask

    task automatic test_stop;
        drive_frame(1, 8, 0, -1, -1, -1);    // capture_en drops mid-frame
        drive_frame(0, -1, 0, -1, -1, -1);
        checks++;
        if (capturing !== 1'b0 || sync_error !== 1'b1) begin
            errors++;
            $display("FAIL stop_status: got cap=%b err=%b want 0 1", capturing, sync_error);
        end
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL stop count: got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL stop write %0d: got cyc=%0d addr=%0d data=%0h want cyc=%0d addr=%0d data=%0h",
                         i, got_w[i].cyc, got_w[i].addr, got_w[i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        checks++;
        if (got_done.size() != exp_done.size()) begin
            errors++;
            $display("FAIL stop done count: got %0d want %0d", got_done.size(), exp_done.size());
        end
        for (int i = 0; i < got_done.size() && i < exp_done.size(); i++) begin
            checks++;
            if (got_done[i] !== exp_done[i]) begin
                errors++;
                $display("FAIL stop done %0d: got cyc=%0d want cyc=%0d", i, got_done[i], exp_done[i]);
            end
        end
        got_w.delete(); exp_w.delete(); got_done.delete(); exp_done.delete();
    endtask

    task automatic test_bad_line;
        drive_frame(0, 12, 1, -1, -1, -1);   // re-arm
        checks++;
        if (sync_error !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", sync_error);
        end
        drive_frame(1, -1, 0, -1, -1, -1);
        checks++;
        if (sync_error !== 1'b0 || capturing !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: got err=%b cap=%b want 0 1", sync_error, capturing);
        end
        drive_frame(1, -1, 0, 10, -1, -1);   // line 10 is one clock short
        checks++;
        if (drop_cyc != short_end + 2 || drop_lp !== 10'(HT - 1)) begin
            errors++;
            $display("FAIL bad_line drop: got cyc=%0d lp=%0d want cyc=%0d lp=%0d", drop_cyc, drop_lp, short_end + 2, HT - 1);
        end
        checks++;
        if (locked !== 1'b0 || sync_error !== 1'b1 || line_period !== 10'(HT)) begin
            errors++;
            $display("FAIL bad_line status: got lock=%b err=%b lp=%0d want 0 1 %0d", locked, sync_error, line_period, HT);
        end
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL bad_line count: got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL bad_line write %0d: got cyc=%0d addr=%0d data=%0h want cyc=%0d addr=%0d data=%0h",
                         i, got_w[i].cyc, got_w[i].addr, got_w[i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        checks++;
        if (got_done.size() != exp_done.size()) begin
            errors++;
            $display("FAIL bad_line done count: got %0d want %0d", got_done.size(), exp_done.size());
        end
        got_w.delete(); exp_w.delete(); got_done.delete(); exp_done.delete();
    endtask

    task automatic test_reset_mid;
        drive_frame(1, -1, 0, -1, -1, 10);   // reset during line 10
        checks++;
        if (capturing !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid status: got cap=%b lock=%b want 0 0", capturing, locked);
        end
        drive_frame(1, -1, 0, -1, -1, -1);   // captured again after a fresh VS
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL reset_mid count: got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL reset_mid write %0d: got cyc=%0d addr=%0d data=%0h want cyc=%0d addr=%0d data=%0h",
                         i, got_w[i].cyc, got_w[i].addr, got_w[i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        checks++;
        if (got_done.size() != exp_done.size()) begin
            errors++;
            $display("FAIL reset_mid done count: got %0d want %0d", got_done.size(), exp_done.size());
        end
        for (int i = 0; i < got_done.size() && i < exp_done.size(); i++) begin
            checks++;
            if (got_done[i] !== exp_done[i]) begin
                errors++;
                $display("FAIL reset_mid done %0d: got cyc=%0d want cyc=%0d", i, got_done[i], exp_done[i]);
            end
        end
        got_w.delete(); exp_w.delete(); got_done.delete(); exp_done.delete();
    endtask

    initial begin
        test_reset();
        test_no_capture();
        test_full_frame();
        test_long_blank();
        test_stop();
        test_bad_line();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Receive-side counterpart of the VGA timing generator. Samples an incoming 640x480@60 VGA stream (HS/VS active-low, BLANK active-high during visible pixels, 8-bit pixel), measures its timing, and writes a 2x2-decimated 320x240 image into video memory through a 17-bit write port. It sits between a VGA source (generator output or external link) and the video memory, and gives the processor a way to read back or verify displayed frames.

## Interface
- H_TOTAL, 800, expected clocks per line (HS fall to HS fall)
- V_TOTAL, 525, expected lines per frame (VS fall to VS fall)
- H_PIXELS, 640, maximum visible pixels per line
- V_PIXELS, 480, maximum visible lines per frame
- vga_clock  in  1  pixel clock (25 MHz); the only clock
- reset  in  1  synchronous, active-high
- capture_en  in  1  level; arm/continue capture
- vga_hs  in  1  horizontal sync, active-low
- vga_vs  in  1  vertical sync, active-low
- vga_blank  in  1  1 = visible pixel
- pixel_in  in  8  pixel value
- mem_wr_en  out  1  write strobe
- mem_address  out  17  write address, (y/2)*320 + x/2
- mem_data  out  8  write data
- frame_done  out  1  one-cycle pulse at the end of each captured frame
- capturing  out  1  high in CAPTURE state
- locked  out  1  timing matches H_TOTAL/V_TOTAL
- sync_error  out  1  sticky; cleared by reset or by entering CAPTURE
- line_period  out  10  last measured clocks per line
- frame_lines  out  10  last measured lines per frame

## Operation
- Input stage: register vga_hs, vga_vs, vga_blank, and pixel_in once (s1), then keep a one-cycle history (s2). hs_fall = s2_hs & ~s1_hs; vs_fall is the same for VS.
- h_cnt (10b): increments each cycle. On hs_fall, line_period <= h_cnt+1 and h_cnt <= 0. Saturates at 1023.
- line_cnt (10b): increments on hs_fall. On vs_fall, frame_lines <= line_cnt and line_cnt <= 0.
- x (10b): increments on each s1_blank=1 cycle and resets on hs_fall. y (9b): increments on the first hs_fall after a line that contained a visible pixel, and resets on vs_fall.
- Write condition: state CAPTURE, s1_blank=1, x<H_PIXELS, y<V_PIXELS, x[0]=0, y[0]=0.
  - mem_address = (y[8:1]<<8) + (y[8:1]<<6) + x[9:1], with a maximum of 76799.
  - mem_data is the s1 pixel.
- Visible pixels with x≥H_PIXELS or y≥V_PIXELS produce no write and set sync_error.
- State machine:
  - IDLE: capture_en=1 -> ARM.
  - ARM: waits for vs_fall -> CAPTURE. capture_en=0 -> IDLE.
  - CAPTURE: on vs_fall, pulse frame_done. If capture_en=1, stay in CAPTURE for continuous capture; otherwise go to IDLE. capture_en dropping mid-frame does not abort; the frame completes.
- Lock:
  - A line is good when line_period==H_TOTAL. A frame is good when frame_lines==V_TOTAL.
  - locked rises after two consecutive good frames in which all lines were good.
  - Any bad hs_fall or vs_fall measurement clears locked immediately and sets sync_error.
  - The first vs_fall after reset is only a measurement start and is not checked.
- Simultaneous hs_fall and vs_fall: hs_fall is processed first, so line_cnt includes that line before frame_lines is latched.

## Timing
- Reset values: mem_wr_en=0, mem_address=0, mem_data=0, frame_done=0, capturing=0, locked=0, sync_error=0, line_period=0, frame_lines=0. State is IDLE and all counters are 0.
- Reset asserted mid-frame aborts on the next edge: no further writes, and capture requires re-arming via a fresh vs_fall.
- Latency: a pixel on pixel_in in cycle n produces mem_wr_en/mem_address/mem_data registered in cycle n+2. Strobe outputs are held for exactly one cycle.
- frame_done is asserted in cycle m+2 for a VS falling edge on the pins in cycle m. The same-cycle line_period/frame_lines update is visible together with it.
- No backpressure: memory must accept one write per cycle. At most one write occurs per 2 clocks within a line.
- Width rules: all counters are unsigned. h_cnt and line_cnt saturate rather than wrap, and saturation forces a bad measurement.

## Test plan
- Reset: hold reset 3 cycles during active stream -> all outputs 0, state IDLE, no mem_wr_en.
- Full frame: standard 800x525 source with pixel_in=x[7:0]^y[7:0], capture_en=1 -> after the arming VS, exactly 76800 writes, address k written once in order 0..76799, and frame_done at the next VS (+2 cycles). locked=1 after the second good frame.
- capture_en=0 throughout -> zero writes, frame_done never, locked still rises, line_period=800, frame_lines=525.
- Bad timing: one line of 799 clocks -> line_period=799, locked drops that cycle, sync_error=1 until the next CAPTURE entry.
- Overlong blank: vga_blank high for 642 clocks on one line -> no write for x≥640, sync_error=1, and the other addresses remain correct.
- Continuous/stop: capture_en deasserted mid-frame 2 -> frame 2 completes with 76800 writes and frame_done, then IDLE with no frame-3 writes. Reset asserted mid-frame 3 -> writes stop within 1 cycle.
